serial_parallel_rx: RTL and testbench
=====================================

# serial_parallel_rx

Serial-to-parallel receiver for the serial link driven by the team's parallel-to-serial transmitter. It samples one bit per `clk_8f` cycle, MSB first, and finds byte alignment by hunting for the idle comma `8'hBC`. After `BC_COUNT` consecutive aligned commas it declares the link active and then delivers every byte, flagging commas as not valid. It sits at the far end of the serial lane and feeds the parallel (`clk_f`-rate) datapath.

## Interface
- `COMMA`, default `8'hBC`: idle/alignment byte the transmitter sends while its `valid_in` is low.
- `BC_COUNT`, default `4`: consecutive aligned commas required before `active` asserts. Legal range 1..15.
- `clk_8f`  in  1: bit clock; all logic on its rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `data_in`  in  1: serial bit, MSB of each byte first.
- `data_out`  out  8: last received non-comma byte.
- `valid_out`  out  1: current byte period carries data (not a comma).
- `byte_strobe`  out  1: one-cycle pulse on each byte boundary while active.
- `active`  out  1: link aligned and delivering bytes; sticky until reset.

## Operation
- Shift register: `sr <= {sr[6:0], data_in}` every cycle. `window = {sr[6:0], data_in}` is the byte that completes on the current edge.
- `bit_cnt` is a 3-bit counter that increments every cycle and wraps 7 -> 0. A byte boundary occurs on a cycle where `bit_cnt == 7`, when `window` holds a full aligned byte.
- `bc_cnt` is 4 bits wide.
- **State HUNT** (reset state):
  - Compare `window` to `COMMA` every cycle, with no alignment assumed.
  - On a match, force `bit_cnt <= 0` (this edge is a boundary) and set `bc_cnt <= 1`.
  - Then go to CHECK. If `BC_COUNT == 1`, go directly to SYNC and set `active <= 1`.
- **State CHECK**: act only at boundaries.
  - `window == COMMA`: `bc_cnt++`. When the incremented value equals `BC_COUNT`, go to SYNC and set `active <= 1`.
  - `window != COMMA`: set `bc_cnt <= 0` and return to HUNT. The non-comma byte is discarded.
- **State SYNC**: act only at boundaries. On every boundary, `byte_strobe <= 1` for that one cycle.
  - `window != COMMA`: `data_out <= window`, `valid_out <= 1`.
  - `window == COMMA`: `valid_out <= 0`; `data_out` holds its previous value.
  - `data_out` and `valid_out` change only at boundaries, so each value is held for exactly 8 cycles.
  - The block never leaves SYNC except by reset.
- The comma that completes alignment does not produce a strobe.

## Timing
- **Reset values**: `data_out = 8'h00`, `valid_out = 0`, `byte_strobe = 0`, `active = 0`, `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state HUNT.
  - `reset` has priority over all other logic.
  - Asserting `reset` mid-byte or mid-CHECK discards all partial alignment. The next edge without reset starts in HUNT.
- **Latency**: the last bit (LSB) of a byte is sampled on edge N. `data_out`, `valid_out` and `byte_strobe` update on that same edge N and are visible after it (0 cycles after the LSB sample; registered outputs).
- `active` rises on the edge that samples the LSB of the `BC_COUNT`-th aligned comma. The first `byte_strobe` follows exactly 8 edges later.
- Byte period is exactly 8 cycles; `byte_strobe` has exactly 7 low cycles between pulses.
- A comma pattern straddling two data bytes after SYNC is ignored, because alignment is locked.
- A false comma in HUNT is caught in CHECK by the next non-comma byte.

## Test plan
- **Reset**: hold `reset` for 3 cycles with random `data_in` -> all outputs 0, state HUNT; `active` stays 0 through 16 cycles of `8'h00`.
- **Clean lock**: send 4×`8'hBC`, then `8'h5A`, then `8'hA5` -> `active` rises on the LSB edge of the 4th comma. `data_out = 8'h5A` with `valid_out = 1` and a strobe 8 edges later, then `8'hA5` 8 edges after that.
- **Misaligned start**: send 3 random bits, then 4×`8'hBC`, then `8'h3C` -> lock occurs and `data_out = 8'h3C`, `valid_out = 1`.
- **Insufficient commas**: send 3×`8'hBC`, then `8'h12`, then 4×`8'hBC`, then `8'h77` -> `active` stays 0 through `8'h12`, then locks on the later commas, and `data_out = 8'h77`.
- **Idle in SYNC**: in SYNC, send `8'hC3`, `8'hBC`, `8'h0F` -> `valid_out` goes 1, 0, 1; strobes continue every 8 cycles; `data_out` reads `8'hC3`, `8'hC3`, `8'h0F`.
- **Reset mid-operation**: assert `reset` for 1 cycle at bit 4 of a data byte in SYNC -> all outputs 0 on the next edge; relock requires 4 fresh commas.

Source files
------------

// File: rtl/serial_parallel_rx_if.sv
// Serial lane bundle between the bit-level link and the serial_parallel_rx receiver.
// master drives the serial bit; slave is the receiver that returns bytes and status.
interface serial_parallel_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: samples MSB-first bits on clk_8f, aligns on a comma byte,
// then delivers every byte with a strobe, marking commas as not valid.
module serial_parallel_rx #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic                 clk_8f,
    input  logic                 reset,
    serial_parallel_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        SYNC  = 2'd2
    } state_t;

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    state_t     state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] bc_cnt;
    logic [7:0] data_out_q;
    logic       valid_out_q;
    logic       byte_strobe_q;
    logic       active_q;

    logic [7:0] window;
    logic       boundary;
    logic       is_comma;
    logic [3:0] bc_cnt_inc;

    // window is the byte completing on this edge, including the bit being sampled now
    assign window     = {sr[6:0], bus.data_in};
    assign boundary   = (bit_cnt == 3'd7);
    assign is_comma   = (window == COMMA);
    assign bc_cnt_inc = bc_cnt + 4'd1;

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state         <= HUNT;
            sr            <= '0;
            bit_cnt       <= '0;
            bc_cnt        <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            byte_strobe_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            sr            <= window;
            bit_cnt       <= bit_cnt + 3'd1;
            byte_strobe_q <= 1'b0;

            unique case (state)
                HUNT: begin
                    if (is_comma) begin
                        // this edge becomes a byte boundary, so the next byte ends at bit_cnt == 7
                        bit_cnt <= '0;
                        bc_cnt  <= 4'd1;
                        if (BC_COUNT == 1) begin
                            state    <= SYNC;
                            active_q <= 1'b1;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt <= bc_cnt_inc;
                            if (bc_cnt_inc == BC_TARGET) begin
                                state    <= SYNC;
                                active_q <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= '0;
                            state  <= HUNT;
                        end
                    end
                end

                SYNC: begin
                    if (boundary) begin
                        byte_strobe_q <= 1'b1;
                        if (is_comma) begin
                            valid_out_q <= 1'b0;
                        end else begin
                            data_out_q  <= window;
                            valid_out_q <= 1'b1;
                        end
                    end
                end

                default: state <= HUNT;
            endcase
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.byte_strobe = byte_strobe_q;
    assign bus.active      = active_q;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: lock, misalignment, false starts, idle commas, reset.
module tb_serial_parallel_rx;

    logic clk_8f;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   mid_strb;

    serial_parallel_rx_if bus  ();
    serial_parallel_rx_if bus1 ();

    assign bus1.data_in = bus.data_in;

    serial_parallel_rx #(
        .COMMA    (8'hBC),
        .BC_COUNT (4)
    ) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    serial_parallel_rx #(
        .COMMA    (8'hBC),
        .BC_COUNT (1)
    ) dut1 (
        .clk_8f (clk_8f),
        .reset  (reset),
        .bus    (bus1.slave)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive on the falling edge, return 1 time unit after the rising edge that sampled it
    task automatic send_bit(input logic b);
        @(negedge clk_8f);
        bus.data_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        mid_strb = 0;
        for (int i = 7; i >= 1; i--) begin
            send_bit(v[i]);
            if (bus.byte_strobe === 1'b1) mid_strb++;
        end
        send_bit(v[0]);
    endtask

    task automatic do_reset(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk_8f);
            reset       = 1'b1;
            bus.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_8f);
            #1;
        end
        @(negedge clk_8f);
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data"},   32'(bus.data_out),    32'h00);
        check({tag, "_valid"},  32'(bus.valid_out),   32'h0);
        check({tag, "_strobe"}, 32'(bus.byte_strobe), 32'h0);
        check({tag, "_active"}, 32'(bus.active),      32'h0);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] data, input logic valid);
        check({tag, "_strobe"}, 32'(bus.byte_strobe), 32'h1);
        check({tag, "_data"},   32'(bus.data_out),    32'(data));
        check({tag, "_valid"},  32'(bus.valid_out),   32'(valid));
        check({tag, "_midstb"}, 32'(mid_strb),        32'h0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mid_strb    = 0;
        reset       = 1'b1;
        bus.data_in = 1'b0;

        // reset with random data, then zeros must not lock
        do_reset(3);
        check_idle("rst");
        send_byte(8'h00);
        send_byte(8'h00);
        check("rst_zero_active", 32'(bus.active), 32'h0);

        // clean lock; the BC_COUNT=1 instance locks on the first comma
        send_byte(8'hBC);
        check("bc1_active", 32'(bus1.active), 32'h1);
        check("bc1_nostrobe", 32'(bus1.byte_strobe), 32'h0);
        send_byte(8'hBC);
        check("bc1_comma_strobe", 32'(bus1.byte_strobe), 32'h1);
        check("bc1_comma_valid", 32'(bus1.valid_out), 32'h0);
        send_byte(8'hBC);
        check("lock_3rd_active", 32'(bus.active), 32'h0);
        send_byte(8'hBC);
        check("lock_4th_active", 32'(bus.active), 32'h1);
        check("lock_4th_strobe", 32'(bus.byte_strobe), 32'h0);
        check("lock_4th_valid", 32'(bus.valid_out), 32'h0);
        send_byte(8'h5A);
        check_byte("lock_5a", 8'h5A, 1'b1);
        send_byte(8'hA5);
        check_byte("lock_a5", 8'hA5, 1'b1);

        // misaligned start
        do_reset(1);
        check_idle("mis_rst");
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("mis_pre_active", 32'(bus.active), 32'h0);
        send_byte(8'hBC);
        check("mis_active", 32'(bus.active), 32'h1);
        send_byte(8'h3C);
        check_byte("mis_3c", 8'h3C, 1'b1);

        // too few commas, then a proper lock
        do_reset(1);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        send_byte(8'h12);
        check("ins_12_active", 32'(bus.active), 32'h0);
        check("ins_12_strobe", 32'(bus.byte_strobe), 32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("ins_3rd_active", 32'(bus.active), 32'h0);
        send_byte(8'hBC);
        check("ins_4th_active", 32'(bus.active), 32'h1);
        send_byte(8'h77);
        check_byte("ins_77", 8'h77, 1'b1);

        // idle comma in SYNC, then a comma straddling two data bytes
        send_byte(8'hC3);
        check_byte("idle_c3", 8'hC3, 1'b1);
        send_byte(8'hBC);
        check_byte("idle_bc", 8'hC3, 1'b0);
        send_byte(8'h0F);
        check_byte("idle_0f", 8'h0F, 1'b1);
        send_byte(8'h0B);
        check_byte("strad_0b", 8'h0B, 1'b1);
        send_byte(8'hC0);
        check_byte("strad_c0", 8'hC0, 1'b1);
        send_bit(1'b0);
        check("strad_strobe_low", 32'(bus.byte_strobe), 32'h0);
        check("strad_hold_data", 32'(bus.data_out), 32'hC0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);

        // reset in the middle of a data byte
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_reset(1);
        check_idle("mid_rst");
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("relock_3rd_active", 32'(bus.active), 32'h0);
        send_byte(8'hBC);
        check("relock_active", 32'(bus.active), 32'h1);
        send_byte(8'h99);
        check_byte("relock_99", 8'h99, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
